panel_share_sched: RTL and testbench

//  Round-robin scheduler that shares one front-panel display register among
//  N_SRC requesters. Each requester gets the panel for DWELL cycles.

---
 rtl/panel_share_sched.sv | 193 +++++++++++++++++++
 tb/tb_panel_share_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_share_sched.sv
// panel_share_sched: round-robin owner of the single front-panel display
// register. Each requesting source is shown for DWELL cycles. An operator
// deposit is routed back to whichever source is on the panel when the
// deposit is accepted.
module panel_share_sched #(
    parameter int N_SRC = 4,
    parameter int WIDTH = 20,
    parameter int DWELL = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_SRC-1:0]         Req,
    input  logic [N_SRC*WIDTH-1:0]   Src_data,
    input  logic                     Hold,
    input  logic                     Deposit_valid,
    input  logic [WIDTH-1:0]         Deposit_data,
    output logic                     Deposit_ready,
    output logic [N_SRC-1:0]         Wr_en,
    output logic [WIDTH-1:0]         Wr_data,
    output logic [WIDTH-1:0]         Panel_data,
    output logic [$clog2(N_SRC)-1:0] Panel_sel,
    output logic                     Panel_valid
);

    localparam int SEL_W = $clog2(N_SRC);
    // A DWELL of 1 still needs a one-bit counter so that the vector is legal.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Cyclic search for the first requester strictly after base. The base
    // itself is reached last, so a sole requester can win again.
    // Result is {found, index}.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N_SRC-1:0] req,
        input logic [SEL_W-1:0] base
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = base;
        for (int i = 1; i <= N_SRC; i++) begin
            k = (int'(base) + i) % N_SRC;
            if (!found && req[SEL_W'(k)]) begin
                found = 1'b1;
                idx   = SEL_W'(k);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [SEL_W-1:0] sel_r, sel_nxt_s;
    logic [SEL_W-1:0] ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] wr_data_r;
    logic             latch_wr_s;
    logic [SEL_W:0]   pick_ptr_s;
    logic [SEL_W:0]   pick_sel_s;

    logic             panel_valid_r, panel_valid_nxt_s;
    logic             deposit_ready_r, deposit_ready_nxt_s;
    logic [N_SRC-1:0] wr_en_r, wr_en_nxt_s;
    logic [WIDTH-1:0] panel_data_r, panel_data_nxt_s;

    // Two arbitration results: from the last grant (IDLE) and from the shown source (SHOW).
    always_comb begin
        pick_ptr_s = rr_pick(Req, ptr_r);
        pick_sel_s = rr_pick(Req, sel_r);
    end

    // FSM state, grant index, last-grant pointer, dwell counter and latched deposit.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            sel_r     <= {SEL_W{1'b0}};
            ptr_r     <= SEL_W'(N_SRC - 1);
            cnt_r     <= {CNT_W{1'b0}};
            wr_data_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_wr_s) begin
                wr_data_r <= Deposit_data;
            end else begin
                wr_data_r <= wr_data_r;
            end
        end
    end

    // Next-state logic: arbitration, dwell countdown, hold and deposit priority.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        latch_wr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_ptr_s[SEL_W]) begin
                    state_nxt_s = ST_SHOW;
                    sel_nxt_s   = pick_ptr_s[SEL_W-1:0];
                    ptr_nxt_s   = pick_ptr_s[SEL_W-1:0];
                    cnt_nxt_s   = CNT_W'(DWELL - 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (Deposit_valid && deposit_ready_r) begin
                    // A deposit beats expiry, hold and a dropped request.
                    state_nxt_s = ST_WRITE;
                    latch_wr_s  = 1'b1;
                end else if (!Req[sel_r]) begin
                    if (pick_sel_s[SEL_W]) begin
                        sel_nxt_s = pick_sel_s[SEL_W-1:0];
                        ptr_nxt_s = pick_sel_s[SEL_W-1:0];
                        cnt_nxt_s = CNT_W'(DWELL - 1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (Hold) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    // Req[sel_r] is set here, so the search always finds someone.
                    sel_nxt_s = pick_sel_s[SEL_W-1:0];
                    ptr_nxt_s = pick_sel_s[SEL_W-1:0];
                    cnt_nxt_s = CNT_W'(DWELL - 1);
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_nxt_s = ST_SHOW;
                cnt_nxt_s   = CNT_W'(DWELL - 1);
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        panel_valid_nxt_s   = (state_nxt_s != ST_IDLE);
        deposit_ready_nxt_s = (state_nxt_s == ST_SHOW);
        if (state_nxt_s == ST_WRITE) begin
            wr_en_nxt_s = {{(N_SRC-1){1'b0}}, 1'b1} << sel_nxt_s;
        end else begin
            wr_en_nxt_s = {N_SRC{1'b0}};
        end
        if (state_nxt_s == ST_IDLE) begin
            panel_data_nxt_s = {WIDTH{1'b0}};
        end else if (state_r != ST_IDLE) begin
            // Data follows the grant index with one cycle of latency.
            panel_data_nxt_s = Src_data[int'(sel_r) * WIDTH +: WIDTH];
        end else begin
            panel_data_nxt_s = panel_data_r;
        end
    end

    // Registered panel and write-back outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            panel_valid_r   <= 1'b0;
            deposit_ready_r <= 1'b0;
            wr_en_r         <= {N_SRC{1'b0}};
            panel_data_r    <= {WIDTH{1'b0}};
        end else begin
            panel_valid_r   <= panel_valid_nxt_s;
            deposit_ready_r <= deposit_ready_nxt_s;
            wr_en_r         <= wr_en_nxt_s;
            panel_data_r    <= panel_data_nxt_s;
        end
    end

    assign Deposit_ready = deposit_ready_r;
    assign Wr_en         = wr_en_r;
    assign Wr_data       = wr_data_r;
    assign Panel_data    = panel_data_r;
    assign Panel_sel     = sel_r;
    assign Panel_valid   = panel_valid_r;

endmodule

// File: tb/tb_panel_share_sched.sv
// Directed bench for panel_share_sched: a DWELL=8 instance and a DWELL=1
// instance share the same stimulus.
module tb_panel_share_sched;

    localparam int N = 4;
    localparam int W = 20;

    logic           Clk;
    logic           Reset_n;
    logic [N-1:0]   Req;
    logic [N*W-1:0] Src_data;
    logic           Hold;
    logic           Deposit_valid;
    logic [W-1:0]   Deposit_data;
    logic           Deposit_ready;
    logic [N-1:0]   Wr_en;
    logic [W-1:0]   Wr_data;
    logic [W-1:0]   Panel_data;
    logic [1:0]     Panel_sel;
    logic           Panel_valid;

    logic           d1_deposit_ready;
    logic [N-1:0]   d1_wr_en;
    logic [W-1:0]   d1_wr_data;
    logic [W-1:0]   d1_panel_data;
    logic [1:0]     d1_panel_sel;
    logic           d1_panel_valid;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    panel_share_sched #(.N_SRC(N), .WIDTH(W), .DWELL(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Src_data(Src_data),
        .Hold(Hold), .Deposit_valid(Deposit_valid), .Deposit_data(Deposit_data),
        .Deposit_ready(Deposit_ready), .Wr_en(Wr_en), .Wr_data(Wr_data),
        .Panel_data(Panel_data), .Panel_sel(Panel_sel), .Panel_valid(Panel_valid)
    );

    panel_share_sched #(.N_SRC(N), .WIDTH(W), .DWELL(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Src_data(Src_data),
        .Hold(Hold), .Deposit_valid(Deposit_valid), .Deposit_data(Deposit_data),
        .Deposit_ready(d1_deposit_ready), .Wr_en(d1_wr_en), .Wr_data(d1_wr_data),
        .Panel_data(d1_panel_data), .Panel_sel(d1_panel_sel), .Panel_valid(d1_panel_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n       = 1'b0;
        Req           = 4'b0000;
        Hold          = 1'b0;
        Deposit_valid = 1'b0;
        Deposit_data  = 20'h00000;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    initial begin
        Src_data = {20'h33333, 20'h22222, 20'hABCDE, 20'h11111};
        do_reset();

        // 1: reset state, then alternation 0 / 2 with 8-cycle dwell.
        check("rst_valid", Panel_valid, 32'd0);
        check("rst_sel",   Panel_sel, 32'd0);
        check("rst_data",  Panel_data, 32'd0);
        check("rst_wr_en", Wr_en, 32'd0);
        check("rst_wr_data", Wr_data, 32'd0);
        check("rst_ready", Deposit_ready, 32'd0);
        Req = 4'b0101;
        for (int i = 0; i < 17; i++) begin
            tick();
            check("t1_sel", Panel_sel, (i < 8) ? 32'd0 : ((i < 16) ? 32'd2 : 32'd0));
            check("t1_valid", Panel_valid, 32'd1);
            if (i < 4) begin
                check("d1_sel", d1_panel_sel, (i % 2 == 0) ? 32'd0 : 32'd2);
            end
            if (i == 0) begin
                check("t1_data_entry", Panel_data, 32'd0);
                check("t1_ready", Deposit_ready, 32'd1);
            end
            if (i == 1) begin
                check("t1_data_src0", Panel_data, 32'h11111);
            end
            if (i == 9) begin
                check("t1_data_src2", Panel_data, 32'h22222);
            end
        end

        // 2: sole requester 1 keeps regranting itself.
        do_reset();
        Req = 4'b0010;
        tick();
        check("t2_sel", Panel_sel, 32'd1);
        check("t2_data_entry", Panel_data, 32'd0);
        tick();
        check("t2_data", Panel_data, 32'hABCDE);
        for (int i = 0; i < 18; i++) begin
            tick();
            check("t2_sel_hold", Panel_sel, 32'd1);
            check("t2_valid", Panel_valid, 32'd1);
        end
        Src_data = {20'h33333, 20'h22222, 20'h54321, 20'h11111};
        tick();
        check("t2_data_new", Panel_data, 32'h54321);
        Src_data = {20'h33333, 20'h22222, 20'hABCDE, 20'h11111};

        // 3: deposit to source 3, dwell restarts; deposit beats expiry.
        do_reset();
        Req = 4'b1000;
        tick();
        check("t3_sel", Panel_sel, 32'd3);
        Req = 4'b1001;
        tick();
        Deposit_valid = 1'b1;
        Deposit_data  = 20'h12345;
        check("t3_ready", Deposit_ready, 32'd1);
        tick();
        Deposit_valid = 1'b0;
        check("t3_wr_en", Wr_en, 32'b1000);
        check("t3_wr_data", Wr_data, 32'h12345);
        check("t3_ready_wr", Deposit_ready, 32'd0);
        check("t3_sel_wr", Panel_sel, 32'd3);
        tick();
        check("t3_wr_en_off", Wr_en, 32'd0);
        check("t3_ready_back", Deposit_ready, 32'd1);
        repeat (7) tick();
        check("t3_restart_sel", Panel_sel, 32'd3);
        tick();
        check("t3_rotate", Panel_sel, 32'd0);
        repeat (7) tick();
        Deposit_valid = 1'b1;
        Deposit_data  = 20'h0BEEF;
        tick();
        Deposit_valid = 1'b0;
        check("t3_exp_dep_wr_en", Wr_en, 32'b0001);
        check("t3_exp_dep_data", Wr_data, 32'h0BEEF);
        check("t3_exp_dep_sel", Panel_sel, 32'd0);
        tick();
        check("t3_exp_keep", Panel_sel, 32'd0);
        repeat (7) tick();
        check("t3_exp_dwell", Panel_sel, 32'd0);
        tick();
        check("t3_exp_rotate", Panel_sel, 32'd3);

        // 4: hold freezes grant 2; release continues remaining dwell; hold lets deposits through.
        do_reset();
        Req = 4'b0100;
        tick();
        check("t4_sel", Panel_sel, 32'd2);
        Req = 4'b1111;
        tick();
        tick();
        Hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_hold_sel", Panel_sel, 32'd2);
        end
        Hold = 1'b0;
        repeat (5) tick();
        check("t4_remaining", Panel_sel, 32'd2);
        tick();
        check("t4_release", Panel_sel, 32'd3);
        Hold          = 1'b1;
        Deposit_valid = 1'b1;
        Deposit_data  = 20'h0CAFE;
        tick();
        check("t4_hold_dep_en", Wr_en, 32'b1000);
        check("t4_hold_dep_data", Wr_data, 32'h0CAFE);
        Hold          = 1'b0;
        Deposit_valid = 1'b0;
        tick();
        check("t4_after_wr", Wr_en, 32'd0);
        check("t4_after_sel", Panel_sel, 32'd3);

        // 5: request drop rearbitrates; no requests goes idle; pointer resumes.
        tick();
        Req = 4'b0101;
        tick();
        check("t5_drop_sel", Panel_sel, 32'd0);
        check("t5_drop_data", Panel_data, 32'h33333);
        Req = 4'b0000;
        tick();
        check("t5_idle_valid", Panel_valid, 32'd0);
        check("t5_idle_data", Panel_data, 32'd0);
        check("t5_idle_ready", Deposit_ready, 32'd0);
        Req = 4'b0010;
        tick();
        check("t5_regrant", Panel_sel, 32'd1);
        check("t5_regrant_valid", Panel_valid, 32'd1);

        // 6: reset drops a pending write strobe and clears everything.
        do_reset();
        Req = 4'b1000;
        tick();
        check("t6_sel", Panel_sel, 32'd3);
        Deposit_valid = 1'b1;
        Deposit_data  = 20'h77777;
        Reset_n       = 1'b0;
        tick();
        check("t6_wr_en", Wr_en, 32'd0);
        check("t6_wr_data", Wr_data, 32'd0);
        check("t6_valid", Panel_valid, 32'd0);
        check("t6_sel_rst", Panel_sel, 32'd0);
        check("t6_ready", Deposit_ready, 32'd0);
        Reset_n       = 1'b1;
        Deposit_valid = 1'b0;
        Req           = 4'b1111;
        tick();
        check("t6_first_grant", Panel_sel, 32'd0);
        Deposit_valid = 1'b1;
        Deposit_data  = 20'h66666;
        tick();
        check("t6_write", Wr_en, 32'b0001);
        Deposit_valid = 1'b0;
        Reset_n       = 1'b0;
        tick();
        check("t6_wr_rst_en", Wr_en, 32'd0);
        check("t6_wr_rst_data", Wr_data, 32'd0);
        check("t6_wr_rst_valid", Panel_valid, 32'd0);
        Reset_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
